// File: rtl/pulse_arbiter_pkg.sv
// Shared encodings for the pulse arbiter and its per-channel edge units.
package pulse_arbiter_pkg;

    // Arbiter grant sequence: wait for a request, strobe the resource, wait for done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Edge unit: turn a button level into a single-cycle pulse per press.
    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_PULSE = 2'd1,
        E_HOLD  = 2'd2
    } edge_state_t;

endpackage

// File: rtl/pulse_arbiter_edge.sv
// Per-channel press detector: one pulse per press, however long the button is held.
module pulse_edge_unit (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    import pulse_arbiter_pkg::*;

    edge_state_t state_q;
    edge_state_t state_d;

    // Next-state: fire once on press, then hold until the button is released.
    always_comb begin
        state_d = E_IDLE;
        case (state_q)
            E_IDLE:  state_d = level ? E_PULSE : E_IDLE;
            E_PULSE: state_d = E_HOLD;
            E_HOLD:  state_d = level ? E_HOLD : E_IDLE;
            default: state_d = E_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= E_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pulse = (state_q == E_PULSE);

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one single-command resource between N button requesters.
module pulse_arbiter #(
    parameter int N   = 4,
    parameter int W   = 2,
    parameter int TMO = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    input  logic         done,
    output logic         start,
    output logic [W-1:0] sel,
    output logic [N-1:0] pend,
    output logic         busy,
    output logic         err
);
    import pulse_arbiter_pkg::*;

    localparam int CW = $clog2(TMO);

    logic [N-1:0] pulse;

    arb_state_t   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;

    logic         found;
    logic [W-1:0] pick;
    logic [W-1:0] idx;
    logic [N-1:0] clr;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_edge
            pulse_edge_unit u_edge (
                .clk   (clk),
                .rst   (rst),
                .level (btn[gi]),
                .pulse (pulse[gi])
            );
        end
    endgenerate

    // Round-robin search: first pending channel after the last granted one.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(ptr_q) + k) % N);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Arbiter next-state, pending bookkeeping and timeout counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    sel_d     = pick;
                    ptr_d     = pick;
                    clr[pick] = 1'b1;
                end
            end
            GRANT: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (done) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A new press on the channel being granted must survive the clear.
        pend_d = (pend_q & ~clr) | pulse;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= W'(N - 1);
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign start = (state_q == GRANT);
    assign busy  = (state_q == GRANT) || (state_q == WAIT);
    assign sel   = sel_q;
    assign pend  = pend_q;
    assign err   = err_q;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: vector table, corner sequences, random run vs model.
module tb_pulse_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       done = 1'b0;
    logic       start;
    logic [1:0] sel;
    logic [3:0] pend;
    logic       busy;
    logic       err;

    pulse_arbiter #(.N(N), .W(2), .TMO(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .done  (done),
        .start (start),
        .sel   (sel),
        .pend  (pend),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: phase 0=idle 1=grant 2=wait; press detector as fire/hold flags.
    int       m_ph, m_ptr, m_sel, m_cnt;
    bit [3:0] m_pend, m_fire, m_hold;
    bit       m_err;

    int start_log[$];
    int start_cyc[$];
    int err_cyc[$];
    int busy_n;
    int dly;

    typedef struct {
        bit       r;
        bit [3:0] b;
        bit       d;
        bit       st;
        bit [1:0] sl;
        bit [3:0] pd;
        bit       bs;
        bit       er;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit [3:0] b, input bit d);
        bit [3:0] pul;
        bit [3:0] nf, nh;
        int g;
        if (!r) begin
            m_ph = 0; m_pend = '0; m_ptr = N - 1; m_sel = 0; m_cnt = 0;
            m_err = 0; m_fire = '0; m_hold = '0;
            return;
        end
        pul = m_fire;
        g = -1;
        if (m_ph == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        m_err = 0;
        case (m_ph)
            0: if (g >= 0) begin m_pend[g] = 0; m_sel = g; m_ptr = g; m_ph = 1; end
            1: begin m_ph = 2; m_cnt = 0; end
            default: begin
                if (d) m_ph = 0;
                else if (m_cnt == TMO - 1) begin m_ph = 0; m_err = 1; end
                else m_cnt++;
            end
        endcase
        m_pend = m_pend | pul;
        for (int i = 0; i < N; i++) begin
            nf[i] = b[i] && !m_fire[i] && !m_hold[i];
            nh[i] = m_fire[i] || (m_hold[i] && b[i]);
        end
        m_fire = nf;
        m_hold = nh;
    endtask

    // One clock: drive inputs, advance model, compare all outputs, log activity.
    task automatic step(input bit r, input bit [3:0] b, input bit d);
        logic [8:0] e;
        rst = r; btn = b; done = d;
        @(posedge clk);
        model_step(r, b, d);
        #1;
        cyc++;
        e = {m_ph == 1, 2'(m_sel), m_pend, m_ph != 0, m_err};
        check("outputs{start,sel,pend,busy,err}", {start, sel, pend, busy, err}, e);
        if (start === 1'b1) begin start_log.push_back(int'(sel)); start_cyc.push_back(cyc); end
        if (busy === 1'b1) busy_n++;
        if (err === 1'b1) err_cyc.push_back(cyc);
        if (!r) dly = 0;
    endtask

    // Hold buttons for n cycles; answer each new start with done after dd WAIT cycles (0 = never).
    task automatic run(input int n, input bit [3:0] b, input int dd);
        for (int i = 0; i < n; i++) begin
            bit d;
            d = (dly == 1);
            step(1'b1, b, d);
            if (dly > 0) dly--;
            if (start === 1'b1 && dd > 0) dly = dd + 1;
        end
    endtask

    task automatic clear_logs();
        start_log.delete(); start_cyc.delete(); err_cyc.delete(); busy_n = 0;
    endtask

    task automatic reset_dut();
        step(1'b0, 4'b0, 1'b0);
        step(1'b0, 4'b0, 1'b0);
        clear_logs();
    endtask

    initial begin
        bit [3:0] rb;
        dly = 0;
        clear_logs();

        // Reset with ch0/ch2 held, then both served in round-robin order.
        tbl[0]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0101, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b0101, 1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'b0101, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'b0101, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].b, tbl[i].d);
            check($sformatf("vec%0d", i), {start, sel, pend, busy, err},
                  {tbl[i].st, tbl[i].sl, tbl[i].pd, tbl[i].bs, tbl[i].er});
        end

        // Single press held long: one grant, busy for GRANT plus three WAIT cycles.
        clear_logs();
        run(10, 4'b0010, 3);
        run(6, 4'b0000, 3);
        check("single_starts", start_log.size(), 1);
        check("single_sel", start_log.size() > 0 ? start_log[0] : -1, 1);
        check("single_busy", busy_n, 4);
        check("single_pend", pend, 4'b0000);

        // Fairness: all pressed together, then a fresh ch0 press after the wrap.
        reset_dut();
        run(20, 4'b1111, 1);
        run(2, 4'b0000, 1);
        run(12, 4'b0001, 1);
        check("rr_count", start_log.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_sel%0d", i), i < start_log.size() ? start_log[i] : -1, i % 4);

        // Timeout on ch2 with ch1 queued behind it.
        reset_dut();
        run(3, 4'b0100, 0);
        run(4, 4'b0110, 0);
        run(20, 4'b0000, 0);
        check("tmo_err_count", err_cyc.size(), 1);
        check("tmo_err_delay",
              (err_cyc.size() > 0 && start_cyc.size() > 0) ? err_cyc[0] - start_cyc[0] : -1, TMO + 1);
        check("tmo_grants", start_log.size(), 2);
        check("tmo_next_sel", start_log.size() > 1 ? start_log[1] : -1, 1);
        check("tmo_next_gap",
              (err_cyc.size() > 0 && start_cyc.size() > 1) ? start_cyc[1] - err_cyc[0] : -1, 1);

        // Collision: ch3 re-pressed during its own WAIT, done while idle ignored.
        reset_dut();
        run(3, 4'b1000, 0);
        run(2, 4'b0000, 0);
        run(2, 4'b1000, 0);
        check("coll_pend3", pend[3], 1'b1);
        check("coll_busy", busy, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        run(6, 4'b0000, 2);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        check("coll_idle_done", {start, busy, err}, 3'b000);
        check("coll_grants", start_log.size(), 2);
        check("coll_sel2", start_log.size() > 1 ? start_log[1] : -1, 3);

        // Reset during WAIT with ch1 pending.
        reset_dut();
        run(3, 4'b0001, 0);
        run(2, 4'b0010, 0);
        run(2, 4'b0000, 0);
        check("rstw_pend_before", pend, 4'b0010);
        step(1'b0, 4'b0000, 1'b1);
        check("rstw_state", {start, pend, busy, err}, 7'b0);
        clear_logs();
        run(20, 4'b0000, 0);
        check("rstw_no_start", start_log.size(), 0);
        check("rstw_no_err", err_cyc.size(), 0);

        // Random traffic against the model, with occasional resets.
        reset_dut();
        rb = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r, d;
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 5) == 0) rb[j] = ~rb[j];
            r = ($urandom_range(0, 199) != 0);
            d = ($urandom_range(0, 3) == 0);
            step(r, rb, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_arbiter.md
Name: pulse_arbiter

Overview:
- Round-robin controller that shares one single-command resource (counter/display/ALU step) between N pushbutton requesters.
- Each raw button level is reduced to a single-cycle request pulse by a per-channel edge unit, then latched as pending.
- The block grants one pending requester at a time: one-cycle start strobe, wait for the resource done pulse, timeout if done never arrives.
- Sits between the debounced/synchronized board buttons and the shared datapath.

Parameters:
N, 4, number of requesters (2..8)
W, 2, width of channel index, ceil(log2(N))
TMO, 16, max cycles to wait for done before abort (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset (0 at a rising clk edge resets all state)
btn  input  N  synchronized button levels, 1 = pressed
done  input  1  resource completion pulse, sampled only in WAIT
start  output  1  one-cycle command strobe to resource
sel  output  W  index of granted channel, valid from start through end of WAIT
pend  output  N  pending-request flags
busy  output  1  1 while in GRANT or WAIT
err  output  1  one-cycle pulse when WAIT times out

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, pend=0, ptr=N-1, sel=0, start=0, busy=0, err=0, timeout counter=0, all edge units to IDLE.
- Edge unit, per channel, 3 states:
  - E_IDLE -> E_PULSE if btn=1, else stay.
  - E_PULSE -> E_HOLD unconditionally.
  - E_HOLD -> E_IDLE when btn=0, else stay.
  - Any unused encoding -> E_IDLE.
  - pulse = (state==E_PULSE): exactly one cycle per press regardless of hold length.
  - A button held through reset yields one pulse after reset.
- pend[i] is set at the edge after pulse[i]. It clears at the edge entering GRANT for channel i. If set and clear coincide, set wins.
- Arbiter FSM:
  - IDLE: if pend!=0, choose first i with pend[i]=1, searching ptr+1, ptr+2, ... modulo N. Next edge: state=GRANT, sel=i, ptr=i, pend[i] cleared.
  - GRANT: start=1 for exactly this cycle. Next edge: state=WAIT, counter=0.
  - WAIT: if done=1 -> IDLE. Else if counter==TMO-1 -> IDLE with err=1 for the following cycle. Else counter++.
  - done outside WAIT is ignored.
- Latency: btn rise sampled at edge 0 -> pulse during cycle 0 -> pend at edge 1 -> start high during cycle after edge 2 (2-cycle press-to-start from IDLE).
- IDLE is always spent for at least one cycle between grants, so no back-to-back start.
- sel holds its last value in IDLE; it only changes on entering GRANT.
- Presses during GRANT/WAIT accumulate in pend, one flag per channel. A repeated press of an already-pending channel is absorbed (no queue depth).
- Wrap-around: ptr=N-1 searches from channel 0. With all channels pending, grants cycle 0,1,..,N-1,0.
- Reset mid-WAIT: abort with no err and no start. A pending done is ignored.
- All outputs are registered or decoded directly from registered state; there is no combinational path from btn or done to any output.

Decomposition:
- Shared package holds the arbiter state encodings (IDLE, GRANT, WAIT) and edge-unit encodings (E_IDLE, E_PULSE, E_HOLD).
- One natural sub-module: pulse_edge_unit (clk, rst, level in, pulse out), instantiated N times with a generate loop.
- Round-robin search stays in the top level.

Test Plan:
- Reset: hold rst=0 for 2 cycles with btn=4'b0101 -> all outputs 0. After release, pulses on ch0 and ch2, grants ch0 then ch2.
- Single press, N=4: btn[1] held 10 cycles, done 3 cycles after start -> exactly one start with sel=1, busy high 4 cycles, pend[1] cleared, no second grant on release/re-hold.
- Fairness: btn=4'b1111 pressed together, done 1 cycle after each start -> sel sequence 0,1,2,3; ptr wraps; a fifth press of ch0 is granted after ch3.
- Timeout, TMO=16: grant ch2, never assert done -> err high for one cycle exactly 16 cycles after WAIT entry, state IDLE, next pending request served.
- Collision: ch3 pressed again (after release) during its own WAIT -> pend[3]=1 and a second grant of ch3 after done. done asserted in IDLE -> no effect.
- Reset mid-WAIT: rst=0 during WAIT with pend=4'b0010 -> pend=0, busy=0, err=0, no start after reset until a new press.
